// File: rtl/even_div_pkg.sv
// Shared types and defaults for the even clock divider controller.
package even_div_pkg;

    // Default half-period counter width.
    localparam int CNT_W_DEF = 8;

    // Half-period loaded at reset (ratio 10).
    localparam int DEFAULT_HALF_DEF = 5;

    // A half-period of zero has no meaning and is rejected at the config port.
    localparam int HALF_ILLEGAL = 0;

    // Controller states: IDLE (output parked low), RUN, STOP (finishing the
    // current period before parking).
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_e;

endpackage

// File: rtl/div_phase_cnt.sv
// Phase counter for the even divider: owns the half-period count and the
// divided clock register, and flags the last cycle of each phase.
module div_phase_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             run_i,
    input  logic [CNT_W-1:0] half_i,
    output logic             clk_div_o,
    output logic             half_end_o,
    output logic             low_end_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_div_q, clk_div_d;
    // Set while a waveform is in progress; its rising edge starts a new
    // waveform with a high phase regardless of the current count.
    logic             active_q, active_d;
    logic             last_cnt;

    assign last_cnt   = (cnt_q == half_i - CNT_W'(1));
    assign half_end_o = active_q && clk_div_q && last_cnt;
    assign low_end_o  = active_q && !clk_div_q && last_cnt;
    assign clk_div_o  = clk_div_q;

    // Next count / level: park low when not running, rise on start or at the
    // end of a low phase, fall at the end of a high phase, otherwise count.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        cnt_d     = cnt_q;
        clk_div_d = clk_div_q;
        active_d  = run_i;
        if (!run_i) begin
            cnt_d     = '0;
            clk_div_d = 1'b0;
        end else if (!active_q || low_end_o) begin
            cnt_d     = '0;
            clk_div_d = 1'b1;
        end else if (half_end_o) begin
            cnt_d     = '0;
            clk_div_d = 1'b0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter and divided-clock registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (!rstn) begin
            cnt_q     <= '0;
            clk_div_q <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            clk_div_q <= clk_div_d;
            active_q  <= active_d;
        end
    end

endmodule

// File: rtl/even_div_ctrl.sv
// Run-time controller for the even clock divider: start/stop FSM, glitch-free
// ratio changes through a one-deep pending-config register, and tick/status.
module even_div_ctrl
    import even_div_pkg::*;
#(
    parameter int CNT_W        = CNT_W_DEF,
    // Must be >= 1.
    parameter int DEFAULT_HALF = DEFAULT_HALF_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_half,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_div,
    output logic             tick,
    output logic [CNT_W-1:0] cur_half,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cur_half_q, cur_half_d;
    logic [CNT_W-1:0] pend_half_q, pend_half_d;
    logic             pend_valid_q, pend_valid_d;
    logic             tick_q, tick_d;
    logic             cfg_err_q, cfg_err_d;

    logic             run;
    logic             half_end;
    logic             low_end;
    logic             boundary;
    logic             cfg_accept;
    logic             cfg_illegal;

    div_phase_cnt #(
        .CNT_W (CNT_W)
    ) u_phase_cnt (
        .clk        (clk),
        .rstn       (rstn),
        .run_i      (run),
        .half_i     (cur_half_q),
        .clk_div_o  (clk_div),
        .half_end_o (half_end),
        .low_end_o  (low_end)
    );

    // Only the end of a low phase is a period boundary; a high-phase end
    // never applies a config or stops the output.
    assign boundary    = low_end && !half_end;

    assign cfg_ready   = !pend_valid_q;
    assign cfg_accept  = cfg_valid && cfg_ready;
    assign cfg_illegal = (cfg_half == CNT_W'(HALF_ILLEGAL));

    assign busy        = (state_q != IDLE);
    assign tick        = tick_q;
    assign cfg_err     = cfg_err_q;
    assign cur_half    = cur_half_q;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: STOP parks only at a period boundary so no runt pulse.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (en) state_d = RUN;
            RUN:     if (!en) state_d = STOP;
            STOP: begin
                if (boundary) begin
                    state_d = IDLE;
                end else if (en) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: counter run request and next tick (each rising edge).
    always_comb begin
        run    = 1'b0;
        tick_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                run    = en;
                tick_d = en;
            end
            RUN: begin
                run    = 1'b1;
                tick_d = boundary;
            end
            STOP: begin
                run    = !boundary;
                tick_d = 1'b0;
            end
            default: begin
                run    = 1'b0;
                tick_d = 1'b0;
            end
        endcase
    end

    // Config handshake: idle updates take effect directly; while running the
    // value waits in the pending register until the next period boundary.
    always_comb begin
        cur_half_d   = cur_half_q;
        pend_half_d  = pend_half_q;
        pend_valid_d = pend_valid_q;
        cfg_err_d    = cfg_accept && cfg_illegal;

        // A pending value still held when the FSM parks (accepted at the
        // stopping boundary) is applied in IDLE so the port cannot stall.
        if (pend_valid_q && (boundary || state_q == IDLE)) begin
            cur_half_d   = pend_half_q;
            pend_valid_d = 1'b0;
        end

        // Mutually exclusive with the apply above: acceptance needs an empty slot.
        if (cfg_accept && !cfg_illegal) begin
            if (state_q == IDLE) begin
                cur_half_d = cfg_half;
            end else begin
                pend_valid_d = 1'b1;
                pend_half_d  = cfg_half;
            end
        end
    end

    // Config, pending and registered-output flops.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cur_half_q   <= CNT_W'(DEFAULT_HALF);
            // NOTE: the pending value is a single register, so it is reset along with its valid bit.
            pend_half_q  <= '0;
            pend_valid_q <= 1'b0;
            tick_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            cur_half_q   <= cur_half_d;
            pend_half_q  <= pend_half_d;
            pend_valid_q <= pend_valid_d;
            tick_q       <= tick_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

endmodule
